// File: rtl/load_pkg.sv
// Shared definitions for the load read path: size codes, FSM state encoding
// and the alignment rule used by both the FSM and its consumers.
package load_pkg;

    localparam int WAIT_W = 4;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ACCESS = 2'd1;
    localparam state_t ST_DONE   = 2'd2;

    // A dword is only reachable on a 64-bit bus; offsets are zero-padded to 3 bits.
    function automatic logic is_misaligned(input logic [2:0] offs,
                                           input logic [1:0] size,
                                           input logic       wide);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = offs[0];
            SZ_WORD: mis = (offs[1:0] != 2'd0);
            default: mis = (offs != 3'd0) || !wide;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_extract.sv
// Byte-lane select and sign/zero extension of a loaded field (little-endian).
module load_extract
    import load_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFFS_W = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] data,
    input  logic [OFFS_W-1:0] offs,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] top;
    logic              msb;

    // The field MSB is found through the top bit of the mask, so a full-width
    // mask leaves ~mask empty and sign_ext has no effect.
    always_comb begin
        shifted = data >> {offs, 3'b000};
        case (size)
            SZ_BYTE: mask = DATA_W'(8'hFF);
            SZ_HALF: mask = DATA_W'(16'hFFFF);
            SZ_WORD: mask = DATA_W'(32'hFFFF_FFFF);
            default: mask = '1;
        endcase
        top    = mask & ~(mask >> 1);
        msb    = |(shifted & top);
        result = (shifted & mask) | ((sign_ext && msb) ? ~mask : '0);
    end

endmodule

// File: rtl/load_read_unit.sv
// Load read unit: accepts a load, strobes memory for WAIT_STATES+1 cycles,
// captures the data and returns the extracted, extended field with a valid pulse.
module load_read_unit
    import load_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int WAIT_STATES = 1,
    parameter int OFFS_W      = $clog2(DATA_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic [OFFS_W-1:0] addr_lo,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_re,
    output logic [DATA_W-1:0] ReadData,
    output logic              read_valid,
    output logic              misaligned,
    output logic              busy
);

    state_t              state;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [OFFS_W-1:0]   offs_q;
    logic [1:0]          size_q;
    logic                sign_q;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                valid_q;
    logic                misal_q;
    logic [DATA_W-1:0]   ext_data;
    logic                req_mis;
    logic                done_mis;

    assign req_mis  = is_misaligned(3'(addr_lo), size, DATA_W == 64);
    assign done_mis = is_misaligned(3'(offs_q), size_q, DATA_W == 64);

    load_extract #(
        .DATA_W (DATA_W),
        .OFFS_W (OFFS_W)
    ) u_extract (
        .data     (data_q),
        .offs     (offs_q),
        .size     (size_q),
        .sign_ext (sign_q),
        .result   (ext_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            offs_q   <= '0;
            size_q   <= '0;
            sign_q   <= 1'b0;
            data_q   <= '0;
            rdata_q  <= '0;
            valid_q  <= 1'b0;
            misal_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            misal_q <= 1'b0;
            rdata_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (MemRead) begin
                        offs_q   <= addr_lo;
                        size_q   <= size;
                        sign_q   <= sign_ext;
                        wait_cnt <= WAIT_W'(WAIT_STATES);
                        state    <= req_mis ? ST_DONE : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (wait_cnt == '0) begin
                        data_q <= mem_rdata;
                        state  <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    // Result is registered here, so the pulse lands in the following IDLE cycle.
                    valid_q <= 1'b1;
                    misal_q <= done_mis;
                    rdata_q <= done_mis ? '0 : ext_data;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_re     = !reset && (state == ST_ACCESS);
    assign busy       = !reset && (state != ST_IDLE);
    assign read_valid = !reset && valid_q;
    assign misaligned = !reset && misal_q;
    assign ReadData   = reset ? '0 : rdata_q;

endmodule
